// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction sequencer: the state
// encoding, the coin unit and the coin-value helper.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam int COIN_UNIT  = 5;
  localparam int COIN_VAL_W = 5;

  // Both coin lines high in one cycle means a 15-unit insertion.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic c5, input logic c10);
    coin_value = (c5  ? COIN_VAL_W'(COIN_UNIT)     : '0)
               + (c10 ? COIN_VAL_W'(2 * COIN_UNIT) : '0);
  endfunction

endpackage

// File: rtl/vend_change_pacer.sv
// Down-counter that ticks periodically while enabled. When disabled it holds
// start_count, so every enable rise begins from a fresh count.
module vend_change_pacer
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] start_count,
  input  logic [W-1:0] reload_count,
  output logic         tick
);

  logic [W-1:0] count;

  assign tick = enable && (count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= start_count;
    end else if (tick) begin
      count <= reload_count;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, dispenser req/ack
// handshake with timeout, and paced change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE        = 15,
  parameter int MAX_CREDIT   = 35,
  parameter int CREDIT_W     = 6,
  parameter int DISP_TIMEOUT = 200,
  parameter int CHANGE_GAP   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int TO_W  = $clog2(DISP_TIMEOUT + 1);
  localparam int GAP_W = $clog2(CHANGE_GAP + 1);

  state_t          st;
  logic            coin_present;
  logic [CREDIT_W:0] sum;
  logic            over;
  logic            price_met;
  logic            timeout_tick;
  logic            change_tick;

  assign state = st;

  // One extra bit on the sum so an overflowing coin is detected, never wrapped.
  assign coin_present = coin_5 | coin_10;
  assign sum          = {1'b0, credit} + (CREDIT_W + 1)'(coin_value(coin_5, coin_10));
  assign over         = sum > (CREDIT_W + 1)'(MAX_CREDIT);
  assign price_met    = credit >= CREDIT_W'(PRICE);

  vend_change_pacer #(.W(TO_W)) u_timeout (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (st == VEND),
    .start_count  (TO_W'(DISP_TIMEOUT - 1)),
    .reload_count (TO_W'(DISP_TIMEOUT - 1)),
    .tick         (timeout_tick)
  );

  // Starting at zero makes the first change pulse land one cycle after entry.
  vend_change_pacer #(.W(GAP_W)) u_change (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (st == CHANGE),
    .start_count  ('0),
    .reload_count (GAP_W'(CHANGE_GAP - 1)),
    .tick         (change_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st           <= IDLE;
      credit       <= '0;
      disp_req     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      case (st)
        IDLE: begin
          if (coin_present) begin
            if (over) begin
              coin_reject <= 1'b1;
            end else begin
              credit <= sum[CREDIT_W-1:0];
              st     <= CREDIT;
            end
          end
        end
        CREDIT: begin
          if (price_met) begin
            // A coin landing on the launch cycle is still credited if it fits.
            st       <= VEND;
            disp_req <= 1'b1;
            if (coin_present && !over) begin
              credit <= sum[CREDIT_W-1:0] - CREDIT_W'(PRICE);
            end else begin
              credit      <= credit - CREDIT_W'(PRICE);
              coin_reject <= coin_present;
            end
          end else if (cancel) begin
            st          <= CHANGE;
            coin_reject <= coin_present;
          end else if (coin_present) begin
            if (over) begin
              coin_reject <= 1'b1;
            end else begin
              credit <= sum[CREDIT_W-1:0];
            end
          end
        end
        VEND: begin
          coin_reject <= coin_present;
          if (disp_ack) begin
            disp_req <= 1'b0;
            st       <= (credit != '0) ? CHANGE : IDLE;
          end else if (timeout_tick) begin
            disp_req <= 1'b0;
            fault    <= 1'b1;
            credit   <= credit + CREDIT_W'(PRICE);
            st       <= FAULT;
          end
        end
        CHANGE: begin
          coin_reject <= coin_present;
          if (credit == '0) begin
            st <= IDLE;
          end else if (change_tick) begin
            credit       <= credit - CREDIT_W'(COIN_UNIT);
            change_pulse <= 1'b1;
          end
        end
        FAULT: begin
          coin_reject <= coin_present;
          fault       <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller: default build plus a
// PRICE=40 / MAX_CREDIT=40 build for the credit-ceiling scenario.
module tb_vend_controller;

  localparam int PRICE        = 15;
  localparam int MAX_CREDIT   = 35;
  localparam int CREDIT_W     = 6;
  localparam int DISP_TIMEOUT = 200;
  localparam int CHANGE_GAP   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_VEND   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic coin_5 = 1'b0, coin_10 = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
  logic disp_req, change_pulse, coin_reject, fault;
  logic [CREDIT_W-1:0] credit;
  logic [2:0] state;

  logic b_coin_5 = 1'b0, b_coin_10 = 1'b0, b_cancel = 1'b0, b_disp_ack = 1'b0;
  logic b_disp_req, b_change_pulse, b_coin_reject, b_fault;
  logic [CREDIT_W-1:0] b_credit;
  logic [2:0] b_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W),
    .DISP_TIMEOUT(DISP_TIMEOUT), .CHANGE_GAP(CHANGE_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .coin_5(coin_5), .coin_10(coin_10),
    .cancel(cancel), .disp_ack(disp_ack), .disp_req(disp_req),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .credit(credit),
    .fault(fault), .state(state)
  );

  vend_controller #(
    .PRICE(40), .MAX_CREDIT(40), .CREDIT_W(CREDIT_W),
    .DISP_TIMEOUT(DISP_TIMEOUT), .CHANGE_GAP(CHANGE_GAP)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .coin_5(b_coin_5), .coin_10(b_coin_10),
    .cancel(b_cancel), .disp_ack(b_disp_ack), .disp_req(b_disp_req),
    .change_pulse(b_change_pulse), .coin_reject(b_coin_reject), .credit(b_credit),
    .fault(b_fault), .state(b_state)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic c5, input logic c10);
    coin_5  = c5;
    coin_10 = c10;
    step();
    coin_5  = 1'b0;
    coin_10 = 1'b0;
  endtask

  task automatic insert_b(input logic c5, input logic c10);
    b_coin_5  = c5;
    b_coin_10 = c10;
    step();
    b_coin_5  = 1'b0;
    b_coin_10 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_compared++;
    if ({state, credit, disp_req, change_pulse, coin_reject, fault} !== {S_IDLE, 6'd0, 4'b0000}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: state=%0d credit=%0d req=%0b pulse=%0b rej=%0b fault=%0b, want all 0",
               state, credit, disp_req, change_pulse, coin_reject, fault);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_exact_price();
    int pulses;
    insert(1'b0, 1'b1);
    n_compared++;
    if ({state, credit} !== {S_CREDIT, 6'd10}) begin
      n_mismatched++;
      $display("[TB] FAIL exact_first_coin: state=%0d credit=%0d, want 1/10", state, credit);
    end
    insert(1'b1, 1'b0);
    n_compared++;
    if ({state, credit} !== {S_CREDIT, 6'd15}) begin
      n_mismatched++;
      $display("[TB] FAIL exact_second_coin: state=%0d credit=%0d, want 1/15", state, credit);
    end
    step();
    n_compared++;
    if ({state, credit, disp_req} !== {S_VEND, 6'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL exact_vend: state=%0d credit=%0d req=%0b, want 2/0/1", state, credit, disp_req);
    end
    step();
    step();
    n_compared++;
    if ({state, disp_req} !== {S_VEND, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL exact_req_held: state=%0d req=%0b, want 2/1", state, disp_req);
    end
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    n_compared++;
    if ({state, disp_req, credit} !== {S_IDLE, 1'b0, 6'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL exact_ack: state=%0d req=%0b credit=%0d, want 0/0/0", state, disp_req, credit);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (change_pulse === 1'b1) pulses++;
    end
    n_compared++;
    if (pulses !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL exact_no_change: pulses=%0d, want 0", pulses);
    end
  endtask

  task automatic test_overpay_change();
    insert(1'b0, 1'b1);
    insert(1'b0, 1'b1);
    n_compared++;
    if ({state, credit} !== {S_CREDIT, 6'd20}) begin
      n_mismatched++;
      $display("[TB] FAIL overpay_credit: state=%0d credit=%0d, want 1/20", state, credit);
    end
    step();
    n_compared++;
    if ({state, credit, disp_req} !== {S_VEND, 6'd5, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL overpay_vend: state=%0d credit=%0d req=%0b, want 2/5/1", state, credit, disp_req);
    end
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    n_compared++;
    if ({state, credit, disp_req, change_pulse} !== {S_CHANGE, 6'd5, 1'b0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL overpay_enter_change: state=%0d credit=%0d req=%0b pulse=%0b, want 3/5/0/0",
               state, credit, disp_req, change_pulse);
    end
    step();
    n_compared++;
    if ({state, credit, change_pulse} !== {S_CHANGE, 6'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL overpay_pulse: state=%0d credit=%0d pulse=%0b, want 3/0/1", state, credit, change_pulse);
    end
    step();
    n_compared++;
    if ({state, change_pulse} !== {S_IDLE, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL overpay_idle: state=%0d pulse=%0b, want 0/0", state, change_pulse);
    end
  endtask

  task automatic test_cancel_coin();
    int early;
    insert(1'b0, 1'b1);
    cancel = 1'b1;
    insert(1'b1, 1'b0);
    cancel = 1'b0;
    n_compared++;
    if ({state, credit, coin_reject} !== {S_CHANGE, 6'd10, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_reject: state=%0d credit=%0d rej=%0b, want 3/10/1", state, credit, coin_reject);
    end
    step();
    n_compared++;
    if ({change_pulse, credit, coin_reject} !== {1'b1, 6'd5, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_first_pulse: pulse=%0b credit=%0d rej=%0b, want 1/5/0", change_pulse, credit, coin_reject);
    end
    early = 0;
    for (int i = 0; i < CHANGE_GAP - 1; i++) begin
      step();
      if (change_pulse !== 1'b0) early++;
    end
    n_compared++;
    if (early !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_gap: early pulses=%0d, want 0", early);
    end
    step();
    n_compared++;
    if ({change_pulse, credit} !== {1'b1, 6'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_second_pulse: pulse=%0b credit=%0d, want 1/0", change_pulse, credit);
    end
    step();
    n_compared++;
    if (state !== S_IDLE) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_idle: state=%0d, want 0", state);
    end
  endtask

  task automatic test_ceiling();
    insert_b(1'b0, 1'b1);
    insert_b(1'b0, 1'b1);
    insert_b(1'b0, 1'b1);
    insert_b(1'b0, 1'b1);
    n_compared++;
    if ({b_state, b_credit, b_coin_reject} !== {S_CREDIT, 6'd40, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL ceiling_accept40: state=%0d credit=%0d rej=%0b, want 1/40/0", b_state, b_credit, b_coin_reject);
    end
    step();
    n_compared++;
    if ({b_state, b_credit, b_disp_req} !== {S_VEND, 6'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL ceiling_vend: state=%0d credit=%0d req=%0b, want 2/0/1", b_state, b_credit, b_disp_req);
    end
    b_disp_ack = 1'b1;
    step();
    b_disp_ack = 1'b0;
    insert_b(1'b0, 1'b1);
    insert_b(1'b0, 1'b1);
    insert_b(1'b0, 1'b1);
    insert_b(1'b1, 1'b0);
    insert_b(1'b0, 1'b1);
    n_compared++;
    if ({b_state, b_credit, b_coin_reject} !== {S_CREDIT, 6'd35, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL ceiling_reject45: state=%0d credit=%0d rej=%0b, want 1/35/1", b_state, b_credit, b_coin_reject);
    end
    step();
    n_compared++;
    if ({b_coin_reject, b_credit} !== {1'b0, 6'd35}) begin
      n_mismatched++;
      $display("[TB] FAIL ceiling_reject_width: rej=%0b credit=%0d, want 0/35", b_coin_reject, b_credit);
    end
    b_cancel = 1'b1;
    step();
    b_cancel = 1'b0;
    for (int i = 0; i < 7 * CHANGE_GAP + 4; i++) step();
    n_compared++;
    if ({b_state, b_credit} !== {S_IDLE, 6'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL ceiling_refund: state=%0d credit=%0d, want 0/0", b_state, b_credit);
    end
  endtask

  task automatic test_timeout();
    int dropped;
    insert(1'b0, 1'b1);
    insert(1'b1, 1'b0);
    step();
    dropped = 0;
    for (int i = 0; i < DISP_TIMEOUT - 1; i++) begin
      step();
      if ({state, disp_req} !== {S_VEND, 1'b1}) dropped++;
    end
    n_compared++;
    if (dropped !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_early: cycles out of VEND=%0d, want 0", dropped);
    end
    step();
    n_compared++;
    if ({state, fault, disp_req, credit} !== {S_FAULT, 1'b1, 1'b0, 6'd15}) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_fault: state=%0d fault=%0b req=%0b credit=%0d, want 4/1/0/15",
               state, fault, disp_req, credit);
    end
    insert(1'b1, 1'b0);
    n_compared++;
    if ({state, coin_reject, credit, fault} !== {S_FAULT, 1'b1, 6'd15, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_coin_reject: state=%0d rej=%0b credit=%0d fault=%0b, want 4/1/15/1",
               state, coin_reject, credit, fault);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_compared++;
    if ({state, credit, disp_req, change_pulse, coin_reject, fault} !== {S_IDLE, 6'd0, 4'b0000}) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_reset: state=%0d credit=%0d req=%0b pulse=%0b rej=%0b fault=%0b, want all 0",
               state, credit, disp_req, change_pulse, coin_reject, fault);
    end
  endtask

  task automatic test_reset_mid_vend();
    insert(1'b1, 1'b1);
    step();
    n_compared++;
    if ({state, disp_req} !== {S_VEND, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL midvend_setup: state=%0d req=%0b, want 2/1", state, disp_req);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_compared++;
    if ({state, disp_req, credit} !== {S_IDLE, 1'b0, 6'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL midvend_abort: state=%0d req=%0b credit=%0d, want 0/0/0", state, disp_req, credit);
    end
  endtask

  task automatic test_back_to_back();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_compared++;
    if ({state, change_pulse, credit} !== {S_IDLE, 1'b0, 6'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL idle_cancel: state=%0d pulse=%0b credit=%0d, want 0/0/0", state, change_pulse, credit);
    end
    insert(1'b0, 1'b1);
    cancel = 1'b1;
    insert(1'b1, 1'b0);
    cancel = 1'b0;
    for (int i = 0; i < 2 * CHANGE_GAP + 2; i++) step();
    insert(1'b1, 1'b1);
    n_compared++;
    if ({state, credit, coin_reject} !== {S_CREDIT, 6'd15, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_restart: state=%0d credit=%0d rej=%0b, want 1/15/0", state, credit, coin_reject);
    end
  endtask

  initial begin
    $display("[TB] vend_controller directed bench");
    test_reset();
    test_exact_price();
    test_overpay_change();
    test_cancel_coin();
    test_ceiling();
    test_timeout();
    test_reset_mid_vend();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
